// File: rtl/idct_mac_lane_if.sv
// Bus bundle for one IDCT MAC lane: skewed sample input, coefficient
// write port, rounded result and the one-cycle forwarding path.
interface idct_mac_lane_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 25,
    parameter int unsigned CW = 8,
    parameter int unsigned OW = 16,
    parameter int unsigned SW = 5
);
    localparam int unsigned AAW = $clog2(N);

    logic              in_valid;
    logic [N*DW-1:0]   d_in;
    logic [SW-1:0]     shift;
    logic              sat_en;
    logic              coef_wr;
    logic [AAW-1:0]    coef_addr;
    logic [CW-1:0]     coef_data;
    logic [OW-1:0]     d_out;
    logic              out_valid;
    logic              sat_flag;
    logic [N*DW-1:0]   d_prop;
    logic              prop_valid;
    logic              busy;

    modport master (
        output in_valid, d_in, shift, sat_en, coef_wr, coef_addr, coef_data,
        input  d_out, out_valid, sat_flag, d_prop, prop_valid, busy
    );

    modport slave (
        input  in_valid, d_in, shift, sat_en, coef_wr, coef_addr, coef_data,
        output d_out, out_valid, sat_flag, d_prop, prop_valid, busy
    );
endinterface

// File: rtl/idct_mac_lane.sv
// One output lane of the systolic IDCT array: an N-tap inner product of a
// skewed input vector against a loadable coefficient row, followed by
// round-half-up, arithmetic right shift and optional saturation. Inputs are
// also forwarded one cycle downstream so lanes can be chained.
module idct_mac_lane #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 25,
    parameter int unsigned CW = 8,
    parameter int unsigned OW = 16,
    parameter int unsigned SW = 5
) (
    input  logic          clk,
    input  logic          reset,
    idct_mac_lane_if.slave bus
);
    localparam int unsigned AW = DW + CW + $clog2(N);

    logic signed [CW-1:0] coef [N];
    logic signed [DW-1:0] samp [N];
    logic signed [AW-1:0] prod [N];

    // Stages 0..N-2 are registered; the last tap is folded into the output stage.
    logic signed [AW-1:0] acc [N-1];
    logic [N-2:0]         v;

    logic signed [AW-1:0] sum_c;
    logic signed [AW-1:0] rnd_c;
    logic signed [AW-1:0] rsum_c;
    logic signed [AW-1:0] shr_c;
    logic [OW-1:0]        res_c;
    logic                 sat_c;

    // Coefficient bank; reset has priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(N); k++) begin
                coef[k] <= '0;
            end
        end else if (bus.coef_wr) begin
            coef[bus.coef_addr] <= $signed(bus.coef_data);
        end
    end

    // Per-tap products, sign-extended to the accumulator width.
    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            samp[k] = $signed(bus.d_in[k*DW +: DW]);
            prod[k] = AW'(samp[k]) * AW'(coef[k]);
        end
    end

    // Accumulate pipeline; an empty slot always carries a zero partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < int'(N) - 1; k++) begin
                acc[k] <= '0;
            end
        end else begin
            v      <= {v[N-3:0], bus.in_valid};
            acc[0] <= bus.in_valid ? prod[0] : '0;
            for (int k = 1; k < int'(N) - 1; k++) begin
                acc[k] <= v[k-1] ? (acc[k-1] + prod[k]) : '0;
            end
        end
    end

    // Final tap, rounding constant and arithmetic shift (ties round toward +inf).
    always_comb begin
        sum_c  = acc[N-2] + prod[N-1];
        rnd_c  = (bus.shift == '0) ? '0 : (AW'(1) << (bus.shift - SW'(1)));
        rsum_c = sum_c + rnd_c;
        shr_c  = rsum_c >>> bus.shift;
    end

    // Clamp to the signed output range or wrap, depending on sat_en.
    always_comb begin
        res_c = shr_c[OW-1:0];
        sat_c = 1'b0;
        if (bus.sat_en) begin
            if (!shr_c[AW-1] && (|shr_c[AW-2:OW-1])) begin
                res_c = {1'b0, {(OW-1){1'b1}}};
                sat_c = 1'b1;
            end else if (shr_c[AW-1] && !(&shr_c[AW-2:OW-1])) begin
                res_c = {1'b1, {(OW-1){1'b0}}};
                sat_c = 1'b1;
            end
        end
    end

    // Output register; d_out and sat_flag read zero whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (reset || !v[N-2]) begin
            bus.d_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.sat_flag  <= 1'b0;
        end else begin
            bus.d_out     <= res_c;
            bus.out_valid <= 1'b1;
            bus.sat_flag  <= sat_c;
        end
    end

    // One-cycle forwarding of samples and valid to the next lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.d_prop     <= '0;
            bus.prop_valid <= 1'b0;
        end else begin
            bus.d_prop     <= bus.d_in;
            bus.prop_valid <= bus.in_valid;
        end
    end

    // Nothing can enter the pipeline while reset is held, so busy is masked then.
    always_comb begin
        bus.busy = !reset && (bus.in_valid || (|v));
    end
endmodule

// File: tb/tb_idct_mac_lane.sv
// Bench for idct_mac_lane: lanes with N=4, 8 and 16 share one skewed
// stimulus stream and are checked every cycle against an inner-product model
// built from recorded inputs and per-cycle coefficient snapshots.
module tb_idct_mac_lane;
    localparam int unsigned DW    = 25;
    localparam int unsigned CW    = 8;
    localparam int unsigned OW    = 16;
    localparam int unsigned SW    = 5;
    localparam int unsigned NMAX  = 16;
    localparam int unsigned NLANE = 3;
    localparam int unsigned BW    = NMAX * DW;
    localparam int          MAXC  = 1024;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [BW-1:0] din      = '0;
    logic [SW-1:0] shift    = '0;
    logic          sat_en   = 1'b0;
    logic          coef_wr  = 1'b0;
    logic [3:0]    caddr    = '0;
    logic [CW-1:0] cdata    = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_ready = 1'b0;

    logic [OW-1:0] got_out  [NLANE];
    logic          got_ov   [NLANE];
    logic          got_sat  [NLANE];
    logic [BW-1:0] got_prop [NLANE];
    logic          got_pv   [NLANE];
    logic          got_busy [NLANE];

    always #5 clk = ~clk;

    for (genvar g = 0; g < int'(NLANE); g++) begin : g_lane
        localparam int unsigned LN  = 4 << g;
        localparam int unsigned LAW = $clog2(LN);
        idct_mac_lane_if #(.N(LN), .DW(DW), .CW(CW), .OW(OW), .SW(SW)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.d_in      = din[LN*DW-1:0];
        assign bus.shift     = shift;
        assign bus.sat_en    = sat_en;
        assign bus.coef_wr   = coef_wr;
        assign bus.coef_addr = caddr[LAW-1:0];
        assign bus.coef_data = cdata;
        idct_mac_lane #(.N(LN), .DW(DW), .CW(CW), .OW(OW), .SW(SW)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign got_out[g]  = bus.d_out;
        assign got_ov[g]   = bus.out_valid;
        assign got_sat[g]  = bus.sat_flag;
        assign got_prop[g] = BW'(bus.d_prop);
        assign got_pv[g]   = bus.prop_valid;
        assign got_busy[g] = bus.busy;
    end

    // Recorded stimulus: values presented before each edge and the
    // coefficient bank each lane holds going into that edge.
    logic [BW-1:0] h_din   [MAXC];
    logic          h_v     [MAXC];
    logic          h_rst   [MAXC];
    logic [SW-1:0] h_shift [MAXC];
    logic          h_sat   [MAXC];
    int            h_coef  [NLANE][MAXC][NMAX];
    int            bank    [NLANE][NMAX];

    logic [OW-1:0] e_out      [NLANE];
    logic          e_ov       [NLANE];
    logic          e_sat      [NLANE];
    logic [BW-1:0] e_prop     [NLANE];
    logic          e_pv       [NLANE];
    logic          e_inflight [NLANE];

    logic [BW-1:0] sched_d [MAXC];
    logic          sched_v [MAXC];

    int row [8] = '{64, 18, -83, -50, 64, 75, -36, -89};

    task automatic chk(string nm, int lane, logic [BW-1:0] got, logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lane_n=%0d cycle=%0d got=%0h expected=%0h", nm, 4 << lane, cyc, got, exp);
        end
    endtask

    // A vector started at edge t is still in the pipe after edge c if it was
    // valid and no reset edge occurred in between.
    function automatic bit survived(int t, int c);
        if (t < 0) return 1'b0;
        if (!h_v[t]) return 1'b0;
        for (int e = t; e <= c; e++) begin
            if (h_rst[e]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_lane(int g, int c);
        int n;
        int t;
        int sh;
        longint s;
        longint r;
        longint hi;
        longint lo;
        logic signed [DW-1:0] x;
        n  = 4 << g;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        e_out[g]      = '0;
        e_ov[g]       = 1'b0;
        e_sat[g]      = 1'b0;
        e_inflight[g] = 1'b0;
        e_prop[g]     = '0;
        e_pv[g]       = h_v[c] && !h_rst[c];
        if (h_rst[c]) return;
        for (int k = 0; k < n; k++) e_prop[g][k*DW +: DW] = h_din[c][k*DW +: DW];
        for (int j = 0; j <= n - 2; j++) begin
            if (survived(c - j, c)) e_inflight[g] = 1'b1;
        end
        t = c - (n - 1);
        if (!survived(t, c)) return;
        s = 0;
        for (int k = 0; k < n; k++) begin
            x = h_din[t+k][k*DW +: DW];
            s = s + longint'(x) * longint'(h_coef[g][t+k][k]);
        end
        sh = int'(h_shift[c]);
        r  = (sh == 0) ? s : ((s + (longint'(1) <<< (sh - 1))) >>> sh);
        e_ov[g] = 1'b1;
        if (h_sat[c] && r > hi) begin
            e_out[g] = OW'(hi);
            e_sat[g] = 1'b1;
        end else if (h_sat[c] && r < lo) begin
            e_out[g] = OW'(lo);
            e_sat[g] = 1'b1;
        end else begin
            e_out[g] = OW'(r);
        end
    endfunction

    // Model: record the inputs each edge sees, then advance the coefficient banks.
    initial begin
        forever begin
            @(posedge clk);
            h_din[cyc]   = din;
            h_v[cyc]     = in_valid;
            h_rst[cyc]   = reset;
            h_shift[cyc] = shift;
            h_sat[cyc]   = sat_en;
            for (int g = 0; g < int'(NLANE); g++) begin
                for (int k = 0; k < int'(NMAX); k++) h_coef[g][cyc][k] = bank[g][k];
                if (reset) begin
                    for (int k = 0; k < int'(NMAX); k++) bank[g][k] = 0;
                end else if (coef_wr) begin
                    bank[g][int'(caddr) % (4 << g)] = int'($signed(cdata));
                end
            end
            for (int g = 0; g < int'(NLANE); g++) model_lane(g, cyc);
            cyc = cyc + 1;
            model_ready = 1'b1;
        end
    end

    // Compare every lane against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                for (int g = 0; g < int'(NLANE); g++) begin
                    chk("d_out",      g, BW'(got_out[g]),  BW'(e_out[g]));
                    chk("out_valid",  g, BW'(got_ov[g]),   BW'(e_ov[g]));
                    chk("sat_flag",   g, BW'(got_sat[g]),  BW'(e_sat[g]));
                    chk("d_prop",     g, got_prop[g],      e_prop[g]);
                    chk("prop_valid", g, BW'(got_pv[g]),   BW'(e_pv[g]));
                    chk("busy",       g, BW'(got_busy[g]),
                        BW'(!reset && (in_valid || e_inflight[g])));
                end
            end
        end
    end

    task automatic step();
        if (cyc >= MAXC - int'(NMAX) - 1) begin
            $display("FAIL step_budget cycle=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        din      = sched_d[cyc];
        in_valid = sched_v[cyc];
        @(posedge clk);
        #1;
    endtask

    task automatic put_vec(int t, logic [BW-1:0] v);
        for (int k = 0; k < int'(NMAX); k++) sched_d[t+k][k*DW +: DW] = v[k*DW +: DW];
        sched_v[t] = 1'b1;
    endtask

    task automatic wr_coef(int a, int d);
        coef_wr = 1'b1;
        caddr   = 4'(a);
        cdata   = CW'(d);
        step();
        coef_wr = 1'b0;
    endtask

    function automatic logic [BW-1:0] fill(int val);
        logic [BW-1:0] b;
        for (int k = 0; k < int'(NMAX); k++) b[k*DW +: DW] = DW'(val);
        return b;
    endfunction

    function automatic logic [BW-1:0] first_only(int val);
        logic [BW-1:0] b;
        b = '0;
        b[DW-1:0] = DW'(val);
        return b;
    endfunction

    function automatic logic [BW-1:0] rand_vec();
        logic [BW-1:0] b;
        for (int k = 0; k < int'(NMAX); k++) b[k*DW +: DW] = DW'($urandom);
        return b;
    endfunction

    // Issue one vector and pin the N=8 lane result to a hand-computed value.
    task automatic run_vec(string nm, logic [BW-1:0] v, logic [OW-1:0] exp_out, logic exp_sat);
        int t0;
        bit seen;
        seen = 1'b0;
        t0   = cyc;
        put_vec(t0, v);
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (got_ov[1]) seen = 1'b1;
        end
        chk({nm, "_seen"}, 1, BW'(seen), BW'(1));
        if (seen) begin
            chk({nm, "_latency"},   1, BW'(cyc - t0),   BW'(8));
            chk({nm, "_dout"},      1, BW'(got_out[1]), BW'(exp_out));
            chk({nm, "_sat"},       1, BW'(got_sat[1]), BW'(exp_sat));
            chk({nm, "_model_out"}, 1, BW'(e_out[1]),   BW'(exp_out));
            chk({nm, "_model_sat"}, 1, BW'(e_sat[1]),   BW'(exp_sat));
            step();
            chk({nm, "_single"},    1, BW'(got_ov[1]),  BW'(0));
        end
        repeat (20) step();
    endtask

    initial begin
        int t0;
        for (int c = 0; c < MAXC; c++) begin
            sched_v[c] = 1'b0;
            sched_d[c] = rand_vec();
        end
        for (int g = 0; g < int'(NLANE); g++) begin
            for (int k = 0; k < int'(NMAX); k++) bank[g][k] = 0;
        end

        // Reset with random traffic and a coefficient write competing with it.
        for (int i = 0; i < 3; i++) sched_v[i] = 1'($urandom_range(0, 1));
        coef_wr = 1'b1;
        caddr   = 4'($urandom);
        cdata   = CW'($urandom_range(1, 127));
        repeat (3) step();
        reset   = 1'b0;
        coef_wr = 1'b0;

        run_vec("zero_coef", fill(1), OW'(0), 1'b0);

        for (int i = 0; i < 8; i++) wr_coef(i, row[i]);
        run_vec("row_ones", fill(1), OW'(-37), 1'b0);
        shift = 5'd7;
        run_vec("row_100_sh7", fill(100), OW'(-29), 1'b0);
        run_vec("row_ones_sh7", fill(1), OW'(0), 1'b0);
        shift = 5'd0;

        for (int i = 1; i < 8; i++) wr_coef(i, 0);
        wr_coef(0, 64);
        sat_en = 1'b1;
        run_vec("sat_pos", first_only(1000000), OW'(32767), 1'b1);
        run_vec("sat_neg", first_only(-1000000), OW'(-32768), 1'b1);
        sat_en = 1'b0;
        run_vec("wrap_pos", first_only(1000000), 16'h9000, 1'b0);

        // Back-to-back random vectors with a reset pulse and writes while busy.
        for (int p = 0; p < 2; p++) begin
            shift  = (p == 0) ? 5'd20 : 5'd12;
            sat_en = (p == 0);
            for (int a = 0; a < int'(NMAX); a++) wr_coef(a, int'($urandom));
            t0 = cyc;
            for (int i = 0; i < 20; i++) put_vec(t0 + i, rand_vec());
            for (int i = 0; i < 40; i++) begin
                reset   = (cyc == t0 + 10);
                coef_wr = 1'($urandom_range(0, 1));
                caddr   = 4'($urandom);
                cdata   = CW'($urandom);
                step();
            end
            reset   = 1'b0;
            coef_wr = 1'b0;
            repeat (20) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
